// File: rtl/peripheral_bfm_master_generic_axi4.sv
// ----------------------------------------------------------------------------
// peripheral_bfm_master_generic_axi4
//
// Command-driven AXI4 master. Each command (addr, len, dir) is turned into one
// complete INCR burst of 32-bit beats. Writes run AW -> W -> B and reads run
// AR -> R. Only one transaction is in flight at a time.
//
// Write beats come from the wd_* valid/ready stream. Read beats leave on the
// rd_* valid/ready stream. Both streams are wired straight through to the AXI
// data channels while their phase is active.
//
// When a transaction completes, done pulses for one cycle and done_resp holds
// the merged response. A per-phase watchdog aborts a transaction whose
// handshake has stalled, and reports DECERR.
//
// Ports
//   aclk, areset                 clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/len   command interface (ready only when idle)
//   wd_valid/ready/data/strb     write-beat stream in
//   rd_valid/ready/data          read-beat stream out
//   done, done_resp, busy        completion pulse, merged response, activity
//   aw*/w*/b*                    AXI4 write address/data/response channels
//   ar*/r*                       AXI4 read address/data channels
// ----------------------------------------------------------------------------
module peripheral_bfm_master_generic_axi4 #(
  parameter logic [3:0]  ID      = 4'h0,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        aclk,
  input  logic        areset,
  // command interface
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  // write-beat stream
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_data,
  input  logic [3:0]  wd_strb,
  // read-beat stream
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  // status
  output logic        done,
  output logic [1:0]  done_resp,
  output logic        busy,
  // write address channel
  output logic [3:0]  awid,
  output logic [31:0] awadr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // write data channel
  output logic [3:0]  wid,
  output logic [31:0] wrdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // write response channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI response severity grows with its encoding
  // (OKAY < EXOKAY < SLVERR < DECERR), so a plain numeric max merges them.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [31:0] addr_r;
  logic [3:0]  len_r;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [1:0]  acc_r, acc_nxt_s;          // running merged response
  logic        err_r, err_nxt_s;          // rlast disagreed with beat count
  logic        bgot_r, bgot_nxt_s;        // B response arrived while still in W
  logic [1:0]  done_resp_r, done_resp_nxt_s;
  logic [31:0] wdog_r, wdog_nxt_s;
  logic        load_cmd_s;
  logic        hs_s;
  logic        wdog_active_s;
  logic        timeout_s;
  logic        last_s;
  logic        w_hs_s;
  logic        r_hs_s;
  logic [1:0]  r_acc_s;
  logic        r_err_s;

  // The IDs returned by the slave are not needed: one transaction at a time.
  logic unused_ids_s;
  assign unused_ids_s = ^{bid, rid};

  assign last_s = (cnt_r == len_r);
  assign w_hs_s = wd_valid & wready;
  assign r_hs_s = rvalid & rd_ready;
  assign r_acc_s = resp_max(acc_r, rresp);
  assign r_err_s = err_r | (rlast != last_s);

  // Handshake detect for the current phase; any handshake clears the watchdog.
  always_comb begin
    hs_s          = 1'b0;
    wdog_active_s = 1'b1;
    case (state_r)
      ST_AW:   hs_s = awready;
      ST_W:    hs_s = w_hs_s | bvalid;
      ST_B:    hs_s = bvalid;
      ST_AR:   hs_s = arready;
      ST_R:    hs_s = r_hs_s;
      default: begin
        hs_s          = 1'b0;
        wdog_active_s = 1'b0;
      end
    endcase
  end

  assign timeout_s = (TIMEOUT != 32'd0) && wdog_active_s && !hs_s &&
                     (wdog_r == 32'(TIMEOUT - 32'd1));

  // Next-state and datapath-update decode for the transaction FSM.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    acc_nxt_s       = acc_r;
    err_nxt_s       = err_r;
    bgot_nxt_s      = bgot_r;
    done_resp_nxt_s = done_resp_r;
    load_cmd_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          load_cmd_s  = 1'b1;
          state_nxt_s = cmd_write ? ST_AW : ST_AR;
          cnt_nxt_s   = 4'd0;
          acc_nxt_s   = 2'b00;
          err_nxt_s   = 1'b0;
          bgot_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AW: begin
        if (timeout_s) begin
          state_nxt_s     = ST_DONE;
          done_resp_nxt_s = RESP_DECERR;
        end else if (awready) begin
          state_nxt_s = ST_W;
        end else begin
          state_nxt_s = ST_AW;
        end
      end
      ST_W: begin
        if (timeout_s) begin
          state_nxt_s     = ST_DONE;
          done_resp_nxt_s = RESP_DECERR;
        end else begin
          // bready is already high in W, so an early B must be kept.
          if (bvalid && !bgot_r) begin
            bgot_nxt_s = 1'b1;
            acc_nxt_s  = bresp;
          end else begin
            bgot_nxt_s = bgot_r;
          end
          if (w_hs_s) begin
            if (last_s) begin
              if (bgot_r) begin
                state_nxt_s     = ST_DONE;
                done_resp_nxt_s = acc_r;
              end else if (bvalid) begin
                state_nxt_s     = ST_DONE;
                done_resp_nxt_s = bresp;
              end else begin
                state_nxt_s = ST_B;
              end
            end else begin
              cnt_nxt_s = cnt_r + 4'd1;
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
      end
      ST_B: begin
        if (timeout_s) begin
          state_nxt_s     = ST_DONE;
          done_resp_nxt_s = RESP_DECERR;
        end else if (bgot_r) begin
          state_nxt_s     = ST_DONE;
          done_resp_nxt_s = acc_r;
        end else if (bvalid) begin
          state_nxt_s     = ST_DONE;
          done_resp_nxt_s = bresp;
        end else begin
          state_nxt_s = ST_B;
        end
      end
      ST_AR: begin
        if (timeout_s) begin
          state_nxt_s     = ST_DONE;
          done_resp_nxt_s = RESP_DECERR;
        end else if (arready) begin
          state_nxt_s = ST_R;
        end else begin
          state_nxt_s = ST_AR;
        end
      end
      ST_R: begin
        if (timeout_s) begin
          state_nxt_s     = ST_DONE;
          done_resp_nxt_s = RESP_DECERR;
        end else if (r_hs_s) begin
          // The beat count alone ends the burst; a misplaced rlast only
          // downgrades the reported response.
          acc_nxt_s = r_acc_s;
          err_nxt_s = r_err_s;
          if (last_s) begin
            state_nxt_s     = ST_DONE;
            done_resp_nxt_s = r_err_s ? RESP_SLVERR : r_acc_s;
          end else begin
            cnt_nxt_s = cnt_r + 4'd1;
          end
        end else begin
          state_nxt_s = ST_R;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Watchdog counts stalled cycles inside one phase and restarts on any
  // handshake or phase change.
  always_comb begin
    wdog_nxt_s = 32'd0;
    if (!wdog_active_s || hs_s || (state_nxt_s != state_r)) begin
      wdog_nxt_s = 32'd0;
    end else begin
      wdog_nxt_s = wdog_r + 32'd1;
    end
  end

  // State and transaction registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r     <= ST_IDLE;
      addr_r      <= 32'd0;
      len_r       <= 4'd0;
      cnt_r       <= 4'd0;
      acc_r       <= 2'b00;
      err_r       <= 1'b0;
      bgot_r      <= 1'b0;
      done_resp_r <= 2'b00;
      wdog_r      <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      acc_r       <= acc_nxt_s;
      err_r       <= err_nxt_s;
      bgot_r      <= bgot_nxt_s;
      done_resp_r <= done_resp_nxt_s;
      wdog_r      <= wdog_nxt_s;
      if (load_cmd_s) begin
        addr_r <= cmd_addr;
        len_r  <= cmd_len;
      end
    end
  end

  // Status decoded from the state register.
  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);
  assign done_resp = done_resp_r;

  // Address channels: payload from the latched command, fixed attributes.
  assign awid    = ID;
  assign awadr   = addr_r;
  assign awlen   = len_r;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = (state_r == ST_AW);

  assign arid    = ID;
  assign araddr  = addr_r;
  assign arlen   = len_r;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (state_r == ST_AR);

  // Write data: the beat stream is gated onto W only while in W.
  assign wid      = ID;
  assign wrdata   = wd_data;
  assign wstrb    = wd_strb;
  assign wvalid   = (state_r == ST_W) & wd_valid;
  assign wd_ready = (state_r == ST_W) & wready;
  assign wlast    = (state_r == ST_W) & last_s;
  assign bready   = (state_r == ST_W) | (state_r == ST_B);

  // Read data: R is passed to the beat stream only while in R.
  assign rd_data  = rdata;
  assign rd_valid = (state_r == ST_R) & rvalid;
  assign rready   = (state_r == ST_R) & rd_ready;

endmodule

// File: tb/tb_peripheral_bfm_master_generic_axi4.sv
// ----------------------------------------------------------------------------
// tb_peripheral_bfm_master_generic_axi4
//
// Directed bench for the AXI4 master. The bench acts as both the command
// source and a simple memory-backed AXI slave. Each step is written out in
// order inside one initial block.
// ----------------------------------------------------------------------------
module tb_peripheral_bfm_master_generic_axi4;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done, busy;
  logic [1:0]  done_resp;
  logic [3:0]  awid, awlen, awcache, wid, arid, arlen, arcache, bid, rid;
  logic [31:0] awadr, araddr, wrdata, rdata;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, awlock, arburst, arlock, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem  [0:255];
  logic [31:0] wbuf [0:15];
  logic [31:0] rbuf [0:15];

  peripheral_bfm_master_generic_axi4 #(.ID(4'h5), .TIMEOUT(16)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .done_resp(done_resp), .busy(busy),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Completion pulse: done for exactly one cycle, then idle again.
  task automatic chk_done(input string tag, input logic [1:0] exp_resp);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_resp"}, 32'(done_resp), 32'(exp_resp));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic wr_txn(input logic [31:0] addr, input logic [3:0] len, input bit gap,
                        input logic [1:0] bresp_v, input string tag);
    int beats, lasts, last_at, cyc;
    logic [7:0] idx;
    beats = 0; lasts = 0; last_at = -1; cyc = 0;
    idx = addr[9:2];
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    #1;
    chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_awvalid"}, 32'(awvalid), 32'd1);
    chk({tag, "_awadr"}, awadr, addr);
    chk({tag, "_awlen"}, 32'(awlen), 32'(len));
    chk({tag, "_cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready = 1'b1;
    while (beats <= 32'(len) && cyc < 100) begin
      wd_valid = gap ? (cyc % 2 == 1) : 1'b1;
      wd_data  = wbuf[beats];
      wd_strb  = 4'hF;
      #1;
      if (wvalid === 1'b1) begin
        mem[idx + 8'(beats)] = wrdata;
        if (wlast === 1'b1) begin
          lasts++;
          last_at = beats;
        end
        beats++;
      end
      tick();
      cyc++;
    end
    wd_valid = 1'b0;
    wready = 1'b0;
    chk({tag, "_beats"}, 32'(beats), 32'(len) + 32'd1);
    chk({tag, "_wlast_count"}, 32'(lasts), 32'd1);
    chk({tag, "_wlast_pos"}, 32'(last_at), 32'(len));
    bvalid = 1'b1; bresp = bresp_v;
    #1;
    chk({tag, "_bready"}, 32'(bready), 32'd1);
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk_done(tag, bresp_v);
  endtask

  task automatic rd_txn(input logic [31:0] addr, input logic [3:0] len,
                        input int stall_at, input int stall_n,
                        input int resp_beat, input logic [1:0] resp_val,
                        input bit bad_last, input logic [1:0] exp_resp, input string tag);
    int beats, cyc, stalled, stall_bad;
    logic [7:0] idx;
    beats = 0; cyc = 0; stalled = 0; stall_bad = 0;
    idx = addr[9:2];
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd1);
    chk({tag, "_araddr"}, araddr, addr);
    chk({tag, "_arlen"}, 32'(arlen), 32'(len));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    while (beats <= 32'(len) && cyc < 100) begin
      rvalid   = 1'b1;
      rdata    = mem[idx + 8'(beats)];
      rresp    = (beats == resp_beat) ? resp_val : 2'b00;
      rlast    = bad_last ? 1'b0 : (beats == 32'(len));
      rd_ready = !(beats == stall_at && stalled < stall_n);
      #1;
      if (rd_ready == 1'b0) begin
        stalled++;
        if (rready !== 1'b0) stall_bad++;
      end
      if (rready === 1'b1 && rd_valid === 1'b1) begin
        rbuf[beats] = rd_data;
        beats++;
      end
      tick();
      cyc++;
    end
    rvalid = 1'b0; rd_ready = 1'b0; rlast = 1'b0; rresp = 2'b00;
    chk({tag, "_beats"}, 32'(beats), 32'(len) + 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalled), (stall_at <= 32'(len)) ? 32'(stall_n) : 32'd0);
    chk({tag, "_rready_held_low"}, 32'(stall_bad), 32'd0);
    chk_done(tag, exp_resp);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = 32'd0;
      rbuf[i] = 32'd0;
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 4'd0;
    wd_valid = 1'b0; wd_data = 32'd0; wd_strb = 4'h0; rd_ready = 1'b0;
    awready = 1'b0; arready = 1'b0; wready = 1'b0;
    bid = 4'h5; bresp = 2'b00; bvalid = 1'b0;
    rid = 4'h5; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    // Reset state and constant attributes.
    areset = 1'b1;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_resp", 32'(done_resp), 32'd0);
    chk("rst_valids", 32'({awvalid, arvalid, wvalid, bready, rready, wd_ready, rd_valid}), 32'd0);
    chk("rst_awadr", awadr, 32'd0);
    chk("rst_awlen", 32'(awlen), 32'd0);
    chk("ids", 32'({awid, wid, arid}), 32'h555);
    chk("aw_attr", 32'({awsize, awburst, awlock, awcache, awprot}), 32'({3'b010, 2'b01, 2'b00, 4'b0000, 3'b000}));
    chk("ar_attr", 32'({arsize, arburst, arlock, arcache, arprot}), 32'({3'b010, 2'b01, 2'b00, 4'b0000, 3'b000}));
    areset = 1'b0;
    tick();

    // Single-beat write then read-back.
    wbuf[0] = 32'hDEADBEEF;
    wr_txn(32'h10, 4'd0, 1'b0, 2'b00, "wr1");
    rd_txn(32'h10, 4'd0, 99, 0, 99, 2'b00, 1'b0, 2'b00, "rd1");
    chk("rd1_data", rbuf[0], 32'hDEADBEEF);

    // Four-beat write with a gapped source, read back with a 5-cycle stall.
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    wr_txn(32'h100, 4'd3, 1'b1, 2'b00, "wr4");
    rd_txn(32'h100, 4'd3, 2, 5, 99, 2'b00, 1'b0, 2'b00, "rd4");
    chk("rd4_d0", rbuf[0], 32'd1);
    chk("rd4_d1", rbuf[1], 32'd2);
    chk("rd4_d2", rbuf[2], 32'd3);
    chk("rd4_d3", rbuf[3], 32'd4);

    // Response merging: EXOKAY on one beat, SLVERR from B, missing rlast.
    rd_txn(32'h100, 4'd1, 99, 0, 1, 2'b01, 1'b0, 2'b01, "rd_exok");
    wbuf[0] = 32'hA5A5_0001; wbuf[1] = 32'hA5A5_0002;
    wr_txn(32'h20, 4'd1, 1'b0, 2'b10, "wr_slverr");
    rd_txn(32'h10, 4'd0, 99, 0, 99, 2'b00, 1'b1, 2'b10, "rd_nolast");

    // Watchdog: arready never rises.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && arvalid === 1'b1; k++) begin
      n++;
      tick();
    end
    chk("to_arvalid_cycles", 32'(n), 32'd16);
    chk("to_arvalid_low", 32'(arvalid), 32'd0);
    chk_done("to", 2'b11);

    // Reset during the second beat of a four-beat write.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready = 1'b1; wd_valid = 1'b1; wd_data = 32'h11; wd_strb = 4'hF;
    tick();
    wd_data = 32'h22;
    #1;
    chk("rstmid_wvalid_before", 32'(wvalid), 32'd1);
    areset = 1'b1;
    #1;
    chk("rstmid_valids", 32'({awvalid, arvalid, wvalid, bready, rready, wd_ready}), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("rstmid_wvalid_held", 32'(wvalid), 32'd0);
    areset = 1'b0; wd_valid = 1'b0; wready = 1'b0;
    tick();
    rd_txn(32'h10, 4'd0, 99, 0, 99, 2'b00, 1'b0, 2'b00, "rd_after_rst");
    chk("rd_after_rst_data", rbuf[0], 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
